// File: rtl/fsmd_result_viewer.sv
// fsmd_result_viewer: captures result bytes from the FSMD core into a small
// buffer, then lets the operator step through them with a debounced push
// button while the selected byte is shown on a two-digit multiplexed
// seven-segment display.
module fsmd_result_viewer #(
  parameter int DEPTH           = 32,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REFRESH_DIV     = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       done_in,
  input  logic       next_btn,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic [4:0] index_out,
  output logic [5:0] count_out,
  output logic       reviewing,
  output logic       overflow
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RFW = $clog2(REFRESH_DIV + 1);
  localparam logic [5:0]     DEPTH_C = 6'(DEPTH);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RFW-1:0] RF_LAST = RFW'(REFRESH_DIV - 1);

  typedef enum logic {CAPTURE = 1'b0, REVIEW = 1'b1} state_t;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [5:0]     count_q, count_d;
  logic [4:0]     rd_ptr_q, rd_ptr_d;
  logic           overflow_q, overflow_d;
  logic [4:0]     index_q, index_d;
  logic [7:0]     disp_q, disp_d;
  logic [6:0]     seg_q, seg_d;
  logic [1:0]     an_q, an_d;
  logic           sync1_q, sync2_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           db_level_q, db_level_d;
  logic           press_q, press_d;
  logic [RFW-1:0] rf_cnt_q, rf_cnt_d;
  logic           digit_sel_q, digit_sel_d;

  logic [7:0]     mem [DEPTH];
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [4:0]     cnt_m1;
  logic [3:0]     nibble;
  logic           btn_raw;

  assign btn_raw = ~sync2_q;

  // Debounce: accept a new level after DEBOUNCE_CYCLES differing samples; pulse on press.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (btn_raw == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d   = '0;
      db_level_d = btn_raw;
      press_d    = btn_raw;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Refresh divider: flip the active digit every REFRESH_DIV cycles.
  always_comb begin
    rf_cnt_d    = rf_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (rf_cnt_q == RF_LAST) begin
      rf_cnt_d    = '0;
      digit_sel_d = ~digit_sel_q;
    end
  end

  // Capture/review control, buffer write decode and next displayed byte/index.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_addr    = count_q[AW-1:0];
    case (state_q)
      CAPTURE: begin
        if (data_valid) begin
          if (count_q < DEPTH_C) begin
            wr_en   = 1'b1;
            count_d = count_q + 6'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end else if (done_in && count_q != 6'd0) begin
          state_d  = REVIEW;
          rd_ptr_d = '0;
        end
      end
      default: begin
        // A new strobe restarts the run; a coincident press is dropped.
        if (data_valid) begin
          state_d    = CAPTURE;
          wr_en      = 1'b1;
          wr_addr    = '0;
          count_d    = 6'd1;
          overflow_d = 1'b0;
          rd_ptr_d   = '0;
        end else if (press_q) begin
          if ({1'b0, rd_ptr_q} == count_q - 6'd1) rd_ptr_d = '0;
          else                                    rd_ptr_d = rd_ptr_q + 5'd1;
        end
      end
    endcase

    // Wraps to 31 when count_d is 32, which is the correct last index.
    cnt_m1 = count_d[4:0] - 5'd1;
    if (wr_en)                  disp_d = data_in;
    else if (state_d == REVIEW) disp_d = mem[rd_ptr_d[AW-1:0]];
    else if (count_d == 6'd0)   disp_d = 8'h00;
    else                        disp_d = mem[cnt_m1[AW-1:0]];

    if (state_d == REVIEW)    index_d = rd_ptr_d;
    else if (count_d == 6'd0) index_d = 5'd0;
    else                      index_d = cnt_m1;

    nibble = digit_sel_d ? disp_q[7:4] : disp_q[3:0];
    seg_d  = hex7(nibble);
    an_d   = digit_sel_d ? 2'b01 : 2'b10;
  end

  // Result buffer storage; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= data_in;
  end

  // All control, conditioning and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= CAPTURE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      index_q     <= '0;
      disp_q      <= 8'h00;
      seg_q       <= 7'b1000000;
      an_q        <= 2'b10;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      press_q     <= 1'b0;
      rf_cnt_q    <= '0;
      digit_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      index_q     <= index_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      sync1_q     <= next_btn;
      sync2_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      press_q     <= press_d;
      rf_cnt_q    <= rf_cnt_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign seg_n     = seg_q;
  assign an_n      = an_q;
  assign index_out = index_q;
  assign count_out = count_q;
  assign reviewing = (state_q == REVIEW);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fsmd_result_viewer.sv
// Directed bench for fsmd_result_viewer with small DEPTH/debounce/refresh.
module tb_fsmd_result_viewer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] data_in;
  logic       data_valid, done_in, next_btn;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic [4:0] index_out;
  logic [5:0] count_out;
  logic       reviewing, overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  fsmd_result_viewer #(.DEPTH(4), .DEBOUNCE_CYCLES(4), .REFRESH_DIV(2)) dut (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
    .done_in(done_in), .next_btn(next_btn), .seg_n(seg_n), .an_n(an_n),
    .index_out(index_out), .count_out(count_out), .reviewing(reviewing),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       done;
    logic [5:0] cnt;
    logic [4:0] idx;
    logic       rev;
    logic       ovf;
  } vec_t;

  vec_t vt[18];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000; 4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100; 4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001; 4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010; 4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000; 4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000; 4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110; 4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110; default: glyph = 7'b0001110;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " count"},     32'(count_out), 32'd0);
    check({tag, " index"},     32'(index_out), 32'd0);
    check({tag, " reviewing"}, 32'(reviewing), 32'd0);
    check({tag, " overflow"},  32'(overflow),  32'd0);
    check({tag, " an_n"},      32'(an_n),      32'b10);
    check({tag, " seg_n"},     32'(seg_n),     32'b1000000);
  endtask

  task automatic apply_vec(input int i);
    data_valid = vt[i].dv;
    data_in    = vt[i].din;
    done_in    = vt[i].done;
    tick();
    check($sformatf("vec%0d count", i),     32'(count_out), 32'(vt[i].cnt));
    check($sformatf("vec%0d index", i),     32'(index_out), 32'(vt[i].idx));
    check($sformatf("vec%0d reviewing", i), 32'(reviewing), 32'(vt[i].rev));
    check($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vt[i].ovf));
    data_valid = 1'b0;
    done_in    = 1'b0;
  endtask

  // Wait (bounded) for each digit slot, then compare its glyph.
  task automatic check_byte(input string nm, input logic [7:0] b);
    logic [1:0] tgt;
    logic [6:0] exp;
    bit got;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      tgt = (d == 0) ? 2'b10 : 2'b01;
      exp = (d == 0) ? glyph(b[3:0]) : glyph(b[7:4]);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        if (an_n == tgt) got = 1'b1;
        else tick();
      end
      if (!got) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s digit%0d: an_n timeout, an_n=%b", nm, d, an_n);
      end else begin
        check($sformatf("%s digit%0d seg_n", nm, d), 32'(seg_n), 32'(exp));
      end
    end
  endtask

  task automatic press(input int low_cycles);
    next_btn = 1'b0;
    repeat (low_cycles) tick();
    next_btn = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    //        dv   din    done cnt idx rev ovf
    vt[0]  = '{1'b1, 8'h12, 1'b0, 6'd1, 5'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h34, 1'b0, 6'd2, 5'd1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'hAB, 1'b0, 6'd3, 5'd2, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 6'd3, 5'd0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 6'd3, 5'd0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 6'd3, 5'd0, 1'b1, 1'b0};
    // new run from REVIEW, then strobe + done together
    vt[6]  = '{1'b1, 8'h5A, 1'b0, 6'd1, 5'd0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h66, 1'b1, 6'd2, 5'd1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 6'd2, 5'd0, 1'b1, 1'b0};
    // restart and overflow a 4-deep buffer with 6 strobes
    vt[9]  = '{1'b1, 8'h77, 1'b0, 6'd1, 5'd0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'h88, 1'b0, 6'd2, 5'd1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'h99, 1'b0, 6'd3, 5'd2, 1'b0, 1'b0};
    vt[12] = '{1'b1, 8'hA5, 1'b0, 6'd4, 5'd3, 1'b0, 1'b0};
    vt[13] = '{1'b1, 8'hBB, 1'b0, 6'd4, 5'd3, 1'b0, 1'b1};
    vt[14] = '{1'b1, 8'hCC, 1'b0, 6'd4, 5'd3, 1'b0, 1'b1};
    vt[15] = '{1'b0, 8'h00, 1'b1, 6'd4, 5'd0, 1'b1, 1'b1};
    vt[16] = '{1'b1, 8'h3C, 1'b0, 6'd1, 5'd0, 1'b0, 1'b0};
    vt[17] = '{1'b0, 8'h00, 1'b1, 6'd1, 5'd0, 1'b1, 1'b0};

    RST = 1'b1; data_in = 8'h00; data_valid = 1'b0; done_in = 1'b0; next_btn = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    RST = 1'b0;
    tick();

    // capture three results and enter review
    for (int i = 0; i <= 5; i++) apply_vec(i);
    check_byte("rev0 12", 8'h12);

    // four clean presses wrap through 3 entries
    press(8); check("press1 index", 32'(index_out), 32'd1); check_byte("press1", 8'h34);
    press(8); check("press2 index", 32'(index_out), 32'd2); check_byte("press2", 8'hAB);
    press(8); check("press3 index", 32'(index_out), 32'd0); check_byte("press3", 8'h12);
    press(8); check("press4 index", 32'(index_out), 32'd1); check_byte("press4", 8'h34);

    // short glitch is rejected
    next_btn = 1'b0;
    repeat (3) tick();
    next_btn = 1'b1;
    repeat (10) tick();
    check("glitch index", 32'(index_out), 32'd1);

    // long press: pulse 6 cycles after the fall, index moves on the 7th edge
    next_btn = 1'b0;
    repeat (6) tick();
    check("lp edge6 index", 32'(index_out), 32'd1);
    tick();
    check("lp edge7 index", 32'(index_out), 32'd2);
    repeat (13) tick();
    next_btn = 1'b1;
    repeat (10) tick();
    check("lp single advance", 32'(index_out), 32'd2);

    // restart, simultaneous strobe/done, overflow, restart after overflow
    for (int i = 6; i <= 14; i++) apply_vec(i);
    check_byte("ovf last", 8'hA5);
    for (int i = 15; i <= 16; i++) apply_vec(i);
    check_byte("new run", 8'h3C);
    apply_vec(17);
    done_in = 1'b1;

    // asynchronous reset mid-review
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    check_reset_outputs("async rst");
    tick();
    RST = 1'b0;
    repeat (3) tick();
    check("done empty reviewing", 32'(reviewing), 32'd0);
    check("done empty count",     32'(count_out), 32'd0);
    done_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
